// File: rtl/mem_bus_arbiter_if.sv
// One valid/ready memory bus: request fields flow master->slave, completion flows back.
// master drives valid/addr/wdata/wstrb; slave returns ready/rdata.
interface mem_bus_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory bus (round-robin or fixed priority); ARB_TIMEOUT_EN adds a forced-completion timeout.
// Latency: request at edge N -> mem_valid from N+1; mem_ready -> master ready in the same cycle; IDLE/BUSY/DONE = 3 cycles min.
// Backpressure: request held in mem_* registers until mem_ready (or timeout); losing master waits with valid held.
module mem_bus_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_arbiter_if.slave      m0,
    mem_bus_arbiter_if.slave      m1,
    mem_bus_arbiter_if.master     mem,
    output logic                  grant,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        last_owner;
    logic        valid_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        req_any;
    logic        winner;
    logic        gnt_valid;
    logic        busy;
    logic        timeout_hit;
    logic        complete;
    logic        abort;
    logic [31:0] rdata_sel;

    assign req_any   = m0.valid | m1.valid;
    assign busy      = (state == BUSY);
    assign gnt_valid = grant ? m1.valid : m0.valid;

    // On a tie, round-robin hands the bus to whoever did not own the last completed transfer.
    always_comb begin
        winner = 1'b0;
        if (m0.valid && m1.valid)
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner;
        else if (m1.valid)
            winner = 1'b1;
    end

    assign complete  = busy && (mem.ready || timeout_hit);
    // A mem_ready in the same cycle as the valid drop still wins over the abort.
    assign abort     = busy && !complete && !gnt_valid;
    assign rdata_sel = timeout_hit ? 32'hDEAD_BEEF : mem.rdata;

    assign m0.ready  = complete && !grant;
    assign m1.ready  = complete &&  grant;
    assign m0.rdata  = (complete && !grant) ? rdata_sel : 32'h0;
    assign m1.rdata  = (complete &&  grant) ? rdata_sel : 32'h0;

    assign mem.valid = valid_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign mem.wstrb = wstrb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            grant      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state   <= BUSY;
                        valid_q <= 1'b1;
                        grant   <= winner;
                        addr_q  <= winner ? m1.addr  : m0.addr;
                        wdata_q <= winner ? m1.wdata : m0.wdata;
                        wstrb_q <= winner ? m1.wstrb : m0.wstrb;
                    end
                end
                BUSY: begin
                    if (complete) begin
                        state      <= DONE;
                        valid_q    <= 1'b0;
                        last_owner <= grant;
                    end else if (abort) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counter holds the number of BUSY cycles already spent, so the hit lands in BUSY cycle TIMEOUT_CYCLES.
    assign timeout_hit = busy && !mem.ready && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= 16'h0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE)
                tmo_cnt <= 16'h0;
            else if (busy && !mem.ready)
                tmo_cnt <= tmo_cnt + 16'h1;
            if (timeout_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = ^16'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance sharing clock and reset.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if rr_m0 ();
    mem_bus_arbiter_if rr_m1 ();
    mem_bus_arbiter_if rr_mem ();
    mem_bus_arbiter_if fp_m0 ();
    mem_bus_arbiter_if fp_m1 ();
    mem_bus_arbiter_if fp_mem ();

    logic        rr_grant, rr_tmo_err, fp_grant, fp_tmo_err;
    logic        auto_rdy = 1'b0;
    logic        man_rdy  = 1'b0;
    logic [31:0] man_rdata = 32'h0;

    // Slave model: zero-wait when auto_rdy, otherwise driven by the stimulus.
    assign rr_mem.ready = auto_rdy ? rr_mem.valid : man_rdy;
    assign rr_mem.rdata = man_rdata;
    assign fp_mem.ready = fp_mem.valid;
    assign fp_mem.rdata = 32'h0;

    mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .reset(reset), .m0(rr_m0), .m1(rr_m1), .mem(rr_mem),
        .grant(rr_grant), .timeout_err(rr_tmo_err)
    );

    mem_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(256)) dut_fp (
        .clk(clk), .reset(reset), .m0(fp_m0), .m1(fp_m1), .mem(fp_mem),
        .grant(fp_grant), .timeout_err(fp_tmo_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts falling edges until a ready pulse shows on the chosen instance.
    task automatic wait_rdy(input bit fp, output int cyc, output logic who, output logic [31:0] addr_seen);
        logic found;
        found = 1'b0;
        cyc = 0;
        who = 1'b0;
        addr_seen = 32'h0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            cyc++;
            if (fp ? (fp_m0.ready | fp_m1.ready) : (rr_m0.ready | rr_m1.ready)) begin
                found = 1'b1;
                who = fp ? fp_m1.ready : rr_m1.ready;
                addr_seen = fp ? fp_mem.addr : rr_mem.addr;
            end
        end
        check("wait_ready_seen", {31'h0, found}, 32'h1);
    endtask

    int          cyc;
    logic        who;
    logic [31:0] a_seen;

    initial begin
        rr_m0.valid = 0; rr_m0.addr = 0; rr_m0.wdata = 0; rr_m0.wstrb = 0;
        rr_m1.valid = 0; rr_m1.addr = 0; rr_m1.wdata = 0; rr_m1.wstrb = 0;
        fp_m0.valid = 0; fp_m0.addr = 0; fp_m0.wdata = 0; fp_m0.wstrb = 0;
        fp_m1.valid = 0; fp_m1.addr = 0; fp_m1.wdata = 0; fp_m1.wstrb = 0;

        #1;
        check("rst_mem_valid", {31'h0, rr_mem.valid}, 32'h0);
        check("rst_mem_addr",  rr_mem.addr, 32'h0);
        check("rst_grant",     {31'h0, rr_grant}, 32'h0);
        check("rst_m0_ready",  {31'h0, rr_m0.ready}, 32'h0);
        check("rst_tmo_err",   {31'h0, rr_tmo_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin with both masters requesting and a zero-wait slave.
        @(negedge clk);
        rr_m0.valid = 1; rr_m0.addr = 32'h10;
        rr_m1.valid = 1; rr_m1.addr = 32'h20;
        auto_rdy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_rdy(1'b0, cyc, who, a_seen);
            check("rr_grant",   {31'h0, who}, {31'h0, t[0]});
            check("rr_gap",     cyc, (t == 0) ? 32'd1 : 32'd3);
            check("rr_addr",    a_seen, t[0] ? 32'h20 : 32'h10);
        end
        rr_m0.valid = 0; rr_m1.valid = 0;
        @(negedge clk);
        auto_rdy = 1'b0;
        @(negedge clk);

        // m0 read with one wait state.
        rr_m0.valid = 1; rr_m0.addr = 32'h0000_0100; rr_m0.wstrb = 4'h0;
        #1 check("rd_idle_valid", {31'h0, rr_mem.valid}, 32'h0);
        @(negedge clk); #1;
        check("rd_busy1_valid", {31'h0, rr_mem.valid}, 32'h1);
        check("rd_busy1_addr",  rr_mem.addr, 32'h0000_0100);
        check("rd_busy1_rdy",   {31'h0, rr_m0.ready}, 32'h0);
        @(negedge clk);
        man_rdy = 1'b1; man_rdata = 32'h1234_5678;
        #1;
        check("rd_busy2_valid", {31'h0, rr_mem.valid}, 32'h1);
        check("rd_m0_ready",    {31'h0, rr_m0.ready}, 32'h1);
        check("rd_m0_rdata",    rr_m0.rdata, 32'h1234_5678);
        check("rd_m1_ready",    {31'h0, rr_m1.ready}, 32'h0);
        check("rd_m1_rdata",    rr_m1.rdata, 32'h0);
        check("rd_grant",       {31'h0, rr_grant}, 32'h0);
        @(negedge clk);
        man_rdy = 1'b0; rr_m0.valid = 0;
        #1;
        check("rd_done_valid", {31'h0, rr_mem.valid}, 32'h0);
        check("rd_done_ready", {31'h0, rr_m0.ready}, 32'h0);
        @(negedge clk);

        // m1 write; its address changes while BUSY.
        rr_m1.valid = 1; rr_m1.addr = 32'h0300_0004; rr_m1.wdata = 32'hAABB_CCDD; rr_m1.wstrb = 4'b0011;
        @(negedge clk); #1;
        check("wr_grant", {31'h0, rr_grant}, 32'h1);
        check("wr_addr",  rr_mem.addr,  32'h0300_0004);
        check("wr_wdata", rr_mem.wdata, 32'hAABB_CCDD);
        check("wr_wstrb", {28'h0, rr_mem.wstrb}, 32'h3);
        rr_m1.addr = 32'hFFFF_0000; rr_m1.wdata = 32'h0; rr_m1.wstrb = 4'hF;
        @(negedge clk); #1;
        check("wr_addr_hold",  rr_mem.addr,  32'h0300_0004);
        check("wr_wstrb_hold", {28'h0, rr_mem.wstrb}, 32'h3);
        man_rdy = 1'b1; man_rdata = 32'h55;
        #1;
        check("wr_m1_ready", {31'h0, rr_m1.ready}, 32'h1);
        check("wr_m1_rdata", rr_m1.rdata, 32'h55);
        check("wr_m0_ready", {31'h0, rr_m0.ready}, 32'h0);
        @(negedge clk);
        man_rdy = 1'b0; rr_m1.valid = 0;
        @(negedge clk);

        // Granted master drops valid mid-BUSY: abort without ready, last owner stays m1.
        rr_m0.valid = 1; rr_m0.addr = 32'h40;
        @(negedge clk); #1;
        check("ab_busy_valid", {31'h0, rr_mem.valid}, 32'h1);
        rr_m0.valid = 0;
        #1 check("ab_no_ready", {31'h0, rr_m0.ready}, 32'h0);
        @(negedge clk); #1;
        check("ab_idle_valid", {31'h0, rr_mem.valid}, 32'h0);
        rr_m0.valid = 1; rr_m1.valid = 1; rr_m1.addr = 32'h80;
        @(negedge clk); #1;
        check("ab_tie_grant", {31'h0, rr_grant}, 32'h0);
        man_rdy = 1'b1;
        #1 check("ab_tie_ready", {31'h0, rr_m0.ready}, 32'h1);
        @(negedge clk);
        man_rdy = 1'b0; rr_m0.valid = 0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rs_m1_grant", {31'h0, rr_grant}, 32'h1);
        check("rs_m1_valid", {31'h0, rr_mem.valid}, 32'h1);

        // Reset in the middle of m1's BUSY, with the slave answering at the same time.
        man_rdy = 1'b1; reset = 1'b1;
        #1;
        check("rs_valid_drop", {31'h0, rr_mem.valid}, 32'h0);
        check("rs_no_ready",   {31'h0, rr_m1.ready}, 32'h0);
        check("rs_addr_clr",   rr_mem.addr, 32'h0);
        @(negedge clk);
        reset = 1'b0; man_rdy = 1'b0;
        rr_m0.valid = 1;
        @(negedge clk); #1;
        check("rs_tie_grant", {31'h0, rr_grant}, 32'h0);
        check("rs_tie_addr",  rr_mem.addr, 32'h40);
        man_rdy = 1'b1;
        #1 check("rs_tie_ready", {31'h0, rr_m0.ready}, 32'h1);
        @(negedge clk);
        man_rdy = 1'b0; rr_m0.valid = 0; rr_m1.valid = 0;
        @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Silent slave: forced completion in the eighth BUSY cycle.
        rr_m0.valid = 1;
        wait_rdy(1'b0, cyc, who, a_seen);
        check("to_cycles", cyc, 32'd8);
        check("to_rdata",  rr_m0.rdata, 32'hDEAD_BEEF);
        rr_m0.valid = 0;
        @(negedge clk);
        @(negedge clk); #1;
        check("to_err_held", {31'h0, rr_tmo_err}, 32'h1);
`else
        check("to_err_off", {31'h0, rr_tmo_err}, 32'h0);
`endif

        // Fixed priority: m0 keeps winning until it stops asking.
        fp_m0.valid = 1; fp_m0.addr = 32'h100;
        fp_m1.valid = 1; fp_m1.addr = 32'h200;
        for (int t = 0; t < 4; t++) begin
            wait_rdy(1'b1, cyc, who, a_seen);
            check("fp_grant", {31'h0, who}, 32'h0);
            check("fp_gap",   cyc, (t == 0) ? 32'd1 : 32'd3);
            check("fp_addr",  a_seen, 32'h100);
        end
        fp_m0.valid = 0;
        wait_rdy(1'b1, cyc, who, a_seen);
        check("fp_m1_grant", {31'h0, who}, 32'h1);
        check("fp_m1_gap",   cyc, 32'd3);
        check("fp_m1_addr",  a_seen, 32'h200);
        fp_m1.valid = 0;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the single valid/ready memory bus (RAM, SPI flash, flash-config and peripheral decode) between two masters:
  - m0: the picorv32 CPU.
  - m1: a secondary master such as DMA or a debug loader.
- Grants one transaction at a time, round-robin or fixed priority.
- Latches the winning request and holds it stable until the slave side returns ready.
- Sits between the masters and the existing address decode / ready-rdata mux.

## Interface
Parameters:
- FIXED_PRIO, 0 — 0: round-robin; 1: m0 always wins a tie.
- TIMEOUT_CYCLES, 256 — cycles to wait for mem_ready before forced completion (only with ARB_TIMEOUT_EN); legal range 2–65535.

Ports:
- clk  in  1  — single clock; everything is rising-edge.
- reset  in  1  — asynchronous, active-high.
- m0_valid, m1_valid  in  1  — request; held with its addr/wdata/wstrb until that master's ready.
- m0_addr, m1_addr  in  32  — byte address.
- m0_wdata, m1_wdata  in  32  — write data.
- m0_wstrb, m1_wstrb  in  4  — byte strobes; 0 = read.
- m0_ready, m1_ready  out  1  — one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32  — read data, valid while the matching ready is high.
- mem_valid  out  1  — registered request to slaves.
- mem_addr  out  32  — registered, latched at grant.
- mem_wdata  out  32  — registered, latched at grant.
- mem_wstrb  out  4  — registered, latched at grant.
- mem_ready  in  1  — slave completion.
- mem_rdata  in  32  — slave read data.
- grant  out  1  — owner of the current or last transaction (0 = m0).
- timeout_err  out  1  — sticky timeout flag.

## Operation
- FSM states:
  - IDLE: mem_valid=0.
  - BUSY: mem_valid=1.
  - DONE: mem_valid=0, one-cycle turnaround so the finished master can drop valid.
- IDLE, when any mX_valid is high:
  - Select the winner.
  - Latch its addr, wdata and wstrb into the mem_* registers.
  - Set grant to the winner and go to BUSY.
- Selection:
  - Single requester wins.
  - Both requesting, FIXED_PRIO=0: the master that did not own the last completed transaction wins. After reset the last owner is m1, so m0 wins the first tie.
  - Both requesting, FIXED_PRIO=1: m0 wins.
- BUSY and mem_ready=1:
  - m<grant>_ready = 1 combinationally in the same cycle.
  - m<grant>_rdata = mem_rdata.
  - Record grant as the last owner; next state DONE.
- BUSY and the granted master drops valid before mem_ready (protocol violation):
  - Abort: next state IDLE, no ready pulse, last owner unchanged.
  - A mem_ready arriving in the same cycle still completes normally.
- DONE → IDLE unconditionally.
- The non-granted master's ready is always 0; its rdata is 32'h0.
- mem_addr, mem_wdata and mem_wstrb change only on the IDLE→BUSY edge. They are stable for the whole of BUSY.
- Reset values: state IDLE, mem_valid 0, mem_addr/wdata/wstrb 0, grant 0, last owner m1, m0/m1_ready 0, rdata 0, timeout_err 0.
- Reset asserted mid-BUSY drops mem_valid immediately (asynchronously); the pending master gets no ready.

## Timing
- Request seen high in IDLE at edge N → mem_valid high from edge N+1.
- mem_ready at cycle k of BUSY → master ready in that same cycle.
- Back-to-back requests from alternating masters cost 3 cycles minimum each (IDLE, BUSY, DONE) with zero-wait slaves.
- mem_ready sampled only in BUSY; ignored in IDLE and DONE.
- Only the current BUSY state gates the ready path (mem_ready → mX_ready). It has no registered ready output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - On reaching TIMEOUT_CYCLES it forces completion: m<grant>_ready=1, m<grant>_rdata=32'hDEADBEEF, next state DONE.
  - timeout_err sets and stays set until reset.
- ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_err tied to 0.

## Test plan
- m0 reads 0x0000_0100, slave ready on the 2nd BUSY cycle with 0x12345678 → mem_valid high 2 cycles, m0_ready single pulse, m0_rdata=0x12345678, grant=0.
- m0 and m1 both request continuously with FIXED_PRIO=0, zero-wait slave → grants alternate 0,1,0,1; each completes 3 cycles apart.
- Same stimulus with FIXED_PRIO=1 and m0 re-requesting right after DONE → m0 granted every time; m1 is served only while m0 is idle.
- m1 writes wstrb=4'b0011, wdata=0xAABBCCDD to 0x0300_0004 while m1 changes its addr mid-BUSY → mem_addr stays 0x0300_0004 until ready.
- Reset asserted for 1 cycle in the middle of BUSY → mem_valid 0 immediately, no ready pulse; after release m0 wins the first tie.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted → ready pulse after 8 BUSY cycles, rdata=0xDEADBEEF, timeout_err=1 and held.
